fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
Parametrised successor to the single-level forwarding unit. Keeps its own shadow pipeline of destination tags for EX, MEM and WB, and forwards the youngest matching in-flight result to every ID-stage source operand. When the youngest producer's data is not ready yet (load-use), it raises a stall and inserts a bubble. Sits between decode/regfile read and the ID/EX pipeline register; one instance serves all RNS domains.

Parameters:
NUM_DOMAINS, 1, RNS domain count; data width DW = NUM_DOMAINS*8
NUM_SRC, 3, source operands per instruction
ADDR_W, 4, register address width
LOAD_AVAIL, 2, stage where load data first becomes forwardable: 1 = MEM, 2 = WB
ZERO_REG, 1, if 1, address 0 never matches (hardwired zero)
STALL_CNT_W, 16, width of the stall-cycle statistics counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pipe_en  in  1  global advance; 0 freezes the tag pipeline
flush  in  1  kill the instruction currently leaving ID
id_valid  in  1  ID holds a real instruction
id_dest  in  ADDR_W  ID destination address
id_wr_en  in  1  ID instruction writes the regfile
id_is_load  in  1  ID instruction is a load
src_addr  in  NUM_SRC*ADDR_W  ID source addresses, operand k at bits [k*ADDR_W +: ADDR_W]
src_used  in  NUM_SRC  operand k is actually read
rf_data  in  NUM_SRC*DW  regfile read data
ex_data  in  DW  EX-stage ALU result (combinational)
mem_data  in  DW  MEM-stage result (ALU result, or load data when LOAD_AVAIL=1)
wb_data  in  DW  WB write data
src_data_fwd  out  NUM_SRC*DW  forwarded operands
fwd_sel  out  NUM_SRC*2  per operand: 00 RF, 01 EX, 10 MEM, 11 WB
stall  out  1  hold IF/ID; bubble into EX
stall_cnt  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Tag entry: {valid, dest, wr_en, is_load}, held in three registered slots: EX, MEM, WB.
- Reset: all slot valid bits = 0, stall_cnt = 0. With all slots invalid, the outputs are fwd_sel = 00, src_data_fwd = rf_data and stall = 0.
- Match for operand k in slot s requires all of: src_used[k]; slot valid; slot wr_en; dest == src_addr[k]; and NOT (ZERO_REG && src_addr[k] == 0).
- Priority: EX > MEM > WB (youngest producer wins). The selected data is ex_data, mem_data or wb_data respectively.
- Availability:
  - A non-load producer is available in every slot.
  - A load is unavailable in EX.
  - A load in MEM is available only if LOAD_AVAIL == 1.
  - A load in WB is always available.
- Stall: stall = OR over operands of "youngest match is unavailable". A stalled operand still drives fwd_sel and data for its match; the consumer ignores them while stall = 1.
- Forwarding path and stall are combinational: zero-cycle latency from inputs.
- Tag advance, when pipe_en = 1 at a rising edge:
  - WB <= MEM, MEM <= EX.
  - EX <= ID tag if id_valid && !stall && !flush; otherwise EX <= bubble (valid = 0).
- pipe_en = 0: all slots hold. stall is still computed. stall_cnt does not count.
- stall_cnt increments on each edge where pipe_en && stall. It saturates at all-ones and never wraps.
- Flush and stall in the same cycle: flush wins. EX receives a bubble either way, and stall drops once the producer advances.
- Load-use penalty: 2 cycles when LOAD_AVAIL = 2, 1 cycle when LOAD_AVAIL = 1. Back-to-back dependent loads stall independently.
- Reset asserted mid-stall: slots clear immediately (asynchronous) and stall drops to 0 in the same delta.
- The same register in MEM and WB selects MEM. id_dest equal to its own source is not a hazard, because ID is not yet in a slot.

Decomposition:
- Package fwd_pkg holds:
  - FWD_SEL_RF/EX/MEM/WB encodings
  - tag struct {valid, dest, wr_en, is_load} parametrised by ADDR_W
  - slot index constants
- Sub-module fwd_src_mux holds the per-operand compare, priority, availability and data mux. It is instantiated NUM_SRC times from a generate loop.
- The top level holds the tag slots, the stall OR-reduce and the counter.

Test Plan:
- Reset, all slots empty, rf_data = 0x11/0x22/0x33 -> fwd_sel = 00 for every operand, outputs equal rf_data, stall = 0.
- ALU write to r5 (non-load) in EX and a new instruction reading r5, ex_data = 0xA7 -> operand 0: fwd_sel = 01, data 0xA7, stall = 0.
- r5 in EX with ex_data = 0x01 and r5 in WB with wb_data = 0x02 -> EX wins, data 0x01.
- Load to r3 followed immediately by a reader of r3, LOAD_AVAIL = 2 -> stall = 1 for exactly 2 cycles, bubbles in EX, then fwd_sel = 11 with wb_data; stall_cnt = 2.
- Source r0 while ZERO_REG = 1 and the EX slot writes r0 -> fwd_sel = 00, no stall.
- Flush during a load-use stall: EX gets a bubble and the stall clears once the load reaches WB. Separately, STALL_CNT_W = 2 with 5 stall cycles -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared encodings, tag record and slot indices for the forwarding/hazard unit.
// Tag dest is sized for the widest supported address; narrower addresses are zero-extended.
package fwd_pkg;

  localparam logic [1:0] FWD_SEL_RF  = 2'b00;
  localparam logic [1:0] FWD_SEL_EX  = 2'b01;
  localparam logic [1:0] FWD_SEL_MEM = 2'b10;
  localparam logic [1:0] FWD_SEL_WB  = 2'b11;

  localparam int unsigned TAG_ADDR_MAX = 8;

  localparam int unsigned NUM_SLOTS = 3;
  localparam int unsigned SLOT_EX   = 0;
  localparam int unsigned SLOT_MEM  = 1;
  localparam int unsigned SLOT_WB   = 2;

  typedef struct packed {
    logic                    valid;
    logic [TAG_ADDR_MAX-1:0] dest;
    logic                    wr_en;
    logic                    is_load;
  } fwd_tag_t;

  // A load only has its data once it reaches the configured load stage.
  function automatic logic slot_avail(input int unsigned slot, input logic is_load,
                                      input int unsigned load_avail);
    logic avail;
    if (!is_load) begin
      avail = 1'b1;
    end else if (slot == SLOT_WB) begin
      avail = 1'b1;
    end else if (slot == SLOT_MEM) begin
      avail = (load_avail == 1);
    end else begin
      avail = 1'b0;
    end
    return avail;
  endfunction

endpackage

// File: rtl/fwd_src_mux.sv
// Per-operand tag compare, youngest-producer priority, load availability and data select.
module fwd_src_mux
  import fwd_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned LOAD_AVAIL = 2,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic [ADDR_W-1:0]           i_src_addr,
  input  logic                        i_src_used,
  input  logic [DW-1:0]               i_rf_data,
  input  logic [DW-1:0]               i_ex_data,
  input  logic [DW-1:0]               i_mem_data,
  input  logic [DW-1:0]               i_wb_data,
  input  fwd_tag_t [NUM_SLOTS-1:0]    i_slots,
  output logic [DW-1:0]               o_data,
  output logic [1:0]                  o_sel,
  output logic                        o_stall
);

  logic [TAG_ADDR_MAX-1:0] w_addr_ext;
  logic                    w_zero;
  logic [NUM_SLOTS-1:0]    w_hit;

  assign w_addr_ext = TAG_ADDR_MAX'(i_src_addr);
  assign w_zero     = (ZERO_REG != 0) && (i_src_addr == '0);

  always_comb begin
    w_hit = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      w_hit[s] = i_src_used && i_slots[s].valid && i_slots[s].wr_en &&
                 (i_slots[s].dest == w_addr_ext) && !w_zero;
    end
  end

  always_comb begin
    o_sel   = FWD_SEL_RF;
    o_data  = i_rf_data;
    o_stall = 1'b0;
    if (w_hit[SLOT_EX]) begin
      o_sel   = FWD_SEL_EX;
      o_data  = i_ex_data;
      o_stall = !slot_avail(SLOT_EX, i_slots[SLOT_EX].is_load, LOAD_AVAIL);
    end else if (w_hit[SLOT_MEM]) begin
      o_sel   = FWD_SEL_MEM;
      o_data  = i_mem_data;
      o_stall = !slot_avail(SLOT_MEM, i_slots[SLOT_MEM].is_load, LOAD_AVAIL);
    end else if (w_hit[SLOT_WB]) begin
      o_sel   = FWD_SEL_WB;
      o_data  = i_wb_data;
      o_stall = !slot_avail(SLOT_WB, i_slots[SLOT_WB].is_load, LOAD_AVAIL);
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Shadow tag pipeline (EX/MEM/WB), per-operand forwarding muxes, load-use stall and
// saturating stall-cycle counter.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 1,
  parameter int unsigned NUM_SRC     = 3,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned LOAD_AVAIL  = 2,
  parameter int unsigned ZERO_REG    = 1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_pipe_en,
  input  logic                        i_flush,
  input  logic                        i_id_valid,
  input  logic [ADDR_W-1:0]           i_id_dest,
  input  logic                        i_id_wr_en,
  input  logic                        i_id_is_load,
  input  logic [NUM_SRC*ADDR_W-1:0]   i_src_addr,
  input  logic [NUM_SRC-1:0]          i_src_used,
  input  logic [NUM_SRC*NUM_DOMAINS*8-1:0] i_rf_data,
  input  logic [NUM_DOMAINS*8-1:0]    i_ex_data,
  input  logic [NUM_DOMAINS*8-1:0]    i_mem_data,
  input  logic [NUM_DOMAINS*8-1:0]    i_wb_data,
  output logic [NUM_SRC*NUM_DOMAINS*8-1:0] o_src_data_fwd,
  output logic [NUM_SRC*2-1:0]        o_fwd_sel,
  output logic                        o_stall,
  output logic [STALL_CNT_W-1:0]      o_stall_cnt
);

  localparam int unsigned DW = NUM_DOMAINS * 8;

  fwd_tag_t [NUM_SLOTS-1:0] r_slots;
  fwd_tag_t                 w_id_tag;
  logic [NUM_SRC-1:0]       w_src_stall;
  logic                     w_stall;
  logic [STALL_CNT_W-1:0]   r_stall_cnt;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_src_mux #(
      .DW         (DW),
      .ADDR_W     (ADDR_W),
      .LOAD_AVAIL (LOAD_AVAIL),
      .ZERO_REG   (ZERO_REG)
    ) u_src_mux (
      .i_src_addr (i_src_addr[k*ADDR_W +: ADDR_W]),
      .i_src_used (i_src_used[k]),
      .i_rf_data  (i_rf_data[k*DW +: DW]),
      .i_ex_data  (i_ex_data),
      .i_mem_data (i_mem_data),
      .i_wb_data  (i_wb_data),
      .i_slots    (r_slots),
      .o_data     (o_src_data_fwd[k*DW +: DW]),
      .o_sel      (o_fwd_sel[k*2 +: 2]),
      .o_stall    (w_src_stall[k])
    );
  end

  assign w_stall = |w_src_stall;

  // A stalled or flushed ID instruction becomes a bubble in EX.
  always_comb begin
    w_id_tag = '0;
    if (i_id_valid && !w_stall && !i_flush) begin
      w_id_tag.valid   = 1'b1;
      w_id_tag.dest    = TAG_ADDR_MAX'(i_id_dest);
      w_id_tag.wr_en   = i_id_wr_en;
      w_id_tag.is_load = i_id_is_load;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slots     <= '0;
      r_stall_cnt <= '0;
    end else if (i_pipe_en) begin
      r_slots[SLOT_WB]  <= r_slots[SLOT_MEM];
      r_slots[SLOT_MEM] <= r_slots[SLOT_EX];
      r_slots[SLOT_EX]  <= w_id_tag;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

  assign o_stall     = w_stall;
  assign o_stall_cnt = r_stall_cnt;

endmodule
